data_ram_responder: RTL and testbench

- Responder end of the MEM-stage RAM interface: a word-organised data memory with byte-enabled writes and a fixed, parameterised access latency.
- Accepts one request (ram_en / ram_write_en / ram_addr / ram_write_data), performs it after LATENCY busy cycles, and returns read data with a one-cycle ram_ready pulse.
- The pipeline stall logic holds the MEM-stage request stable while ram_ready is low.

---
 rtl/data_ram_responder.sv | 101 ++++++++++
 tb/tb_data_ram_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/data_ram_responder.sv
// Word-organised data RAM responder with byte-enabled writes and a fixed
// access latency; one request in flight, completion signalled by ram_ready.
module data_ram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_en,
  input  logic [3:0]  ram_write_en,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_write_data,
  output logic [31:0] ram_read_data,
  output logic        ram_ready,
  output logic        ram_busy,
  output logic        ram_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [1:0]              cnt;
  logic [ADDR_WIDTH-1:0]   idx_p0;
  logic [3:0]              we_p0;
  logic [31:0]             wdata_p0;
  logic                    oor_p0;
  logic [31:0]             mem [DEPTH];
  logic [31:0]             merged;
  logic                    complete;
  logic                    unused_addr_bits;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++)
      if (be[i]) result[8*i +: 8] = new_word[8*i +: 8];
    return result;
  endfunction

  function automatic logic out_of_range(input logic [31:0] addr);
    return |addr[31:ADDR_WIDTH+2];
  endfunction

  // The initiator word-aligns, so the byte offset carries no information.
  assign unused_addr_bits = ^ram_addr[1:0];

  assign complete = (state == BUSY) && (cnt == 2'd0);
  // With no lanes enabled the merge is just the stored word, so reads share it.
  assign merged   = lane_merge(mem[idx_p0], wdata_p0, we_p0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ram_en) state_next = BUSY;
      BUSY:    if (cnt == 2'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_ready = (state == DONE);
    ram_busy  = (state != IDLE);
    ram_err   = (state == DONE) && oor_p0;
  end

  always_ff @(posedge clk) begin
    if (rst)                          cnt <= 2'd0;
    else if (state == IDLE && ram_en) cnt <= 2'(LATENCY - 1);
    else if (state == BUSY && cnt != 2'd0) cnt <= cnt - 2'd1;
  end

  // Stage p0: request capture; later input changes are ignored until DONE.
  always_ff @(posedge clk) begin
    if (state == IDLE && ram_en) begin
      idx_p0   <= ram_addr[ADDR_WIDTH+1:2];
      we_p0    <= ram_write_en;
      wdata_p0 <= ram_write_data;
      oor_p0   <= out_of_range(ram_addr);
    end
    if (complete && !rst && !oor_p0 && we_p0 != 4'b0000)
      mem[idx_p0] <= merged;
  end

  // Stage p1: write-first read data, held until the next completion.
  always_ff @(posedge clk) begin
    if (rst)           ram_read_data <= 32'h0;
    else if (complete) ram_read_data <= oor_p0 ? 32'h0 : merged;
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: one instance at LATENCY=1 and one at
// LATENCY=4 share the request bus; sel chooses which one sees ram_en.
module tb_data_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sel;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        en1, en4;
  logic [31:0] rd1, rd4;
  logic        ready1, ready4, busy1, busy4, err1, err4;
  logic [31:0] rd_s;
  logic        ready_s, busy_s, err_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign en1     = en & ~sel;
  assign en4     = en & sel;
  assign rd_s    = sel ? rd4 : rd1;
  assign ready_s = sel ? ready4 : ready1;
  assign busy_s  = sel ? busy4 : busy1;
  assign err_s   = sel ? err4 : err1;

  data_ram_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .ram_en(en1), .ram_write_en(we), .ram_addr(addr),
    .ram_write_data(wdata), .ram_read_data(rd1), .ram_ready(ready1),
    .ram_busy(busy1), .ram_err(err1));

  data_ram_responder #(.ADDR_WIDTH(10), .LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .ram_en(en4), .ram_write_en(we), .ram_addr(addr),
    .ram_write_data(wdata), .ram_read_data(rd4), .ram_ready(ready4),
    .ram_busy(busy4), .ram_err(err4));

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE
  // cycle. lat_o counts cycles from accept cycle to ready (-1 on timeout).
  task automatic do_access(input logic [3:0] we_i, input logic [31:0] addr_i,
                           input logic [31:0] wdata_i, input bit scramble,
                           output logic [31:0] rd_o, output logic err_o,
                           output int lat_o, output int busy_o);
    we = we_i; addr = addr_i; wdata = wdata_i; en = 1'b1;
    lat_o = -1; busy_o = 0; rd_o = 32'hx; err_o = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy_s) busy_o++;
      if (ready_s) begin
        lat_o = n; rd_o = rd_s; err_o = err_s;
        break;
      end
      if (scramble) begin
        wdata = ~wdata ^ 32'(n);
        addr  = addr + 32'd4;
      end
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (rd1 !== 32'h0) begin failures++; $display("FAIL reset_rd1: got %h expected %h", rd1, 32'h0); end
    checks++; if ({ready1, busy1, err1} !== 3'b000) begin failures++; $display("FAIL reset_flags1: got %b expected 000", {ready1, busy1, err1}); end
    checks++; if (rd4 !== 32'h0) begin failures++; $display("FAIL reset_rd4: got %h expected %h", rd4, 32'h0); end
    checks++; if ({ready4, busy4, err4} !== 3'b000) begin failures++; $display("FAIL reset_flags4: got %b expected 000", {ready4, busy4, err4}); end
  endtask

  task automatic test_basic();
    logic [31:0] r; logic e; int lat, bc;
    sel = 1'b0;
    do_access(4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, r, e, lat, bc);
    checks++; if (lat !== 2) begin failures++; $display("FAIL basic_wr_latency: got %0d expected 2", lat); end
    checks++; if (bc !== 2) begin failures++; $display("FAIL basic_wr_busy: got %0d expected 2", bc); end
    checks++; if (r !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_wr_data: got %h expected DEADBEEF", r); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL basic_wr_err: got %b expected 0", e); end
    do_access(4'b0000, 32'h10, 32'h0, 1'b0, r, e, lat, bc);
    checks++; if (lat !== 2) begin failures++; $display("FAIL basic_rd_latency: got %0d expected 2", lat); end
    checks++; if (bc !== 2) begin failures++; $display("FAIL basic_rd_busy: got %0d expected 2", bc); end
    checks++; if (r !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rd_data: got %h expected DEADBEEF", r); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r; logic e; int lat, bc;
    sel = 1'b0;
    do_access(4'b0100, 32'h10, 32'h00AB0000, 1'b0, r, e, lat, bc);
    checks++; if (r !== 32'hDEABBEEF) begin failures++; $display("FAIL lane_wr_data: got %h expected DEABBEEF", r); end
    do_access(4'b0000, 32'h10, 32'h0, 1'b0, r, e, lat, bc);
    checks++; if (r !== 32'hDEABBEEF) begin failures++; $display("FAIL lane_rd_data: got %h expected DEABBEEF", r); end
    do_access(4'b1001, 32'h14, 32'h11223344, 1'b0, r, e, lat, bc);
    do_access(4'b0110, 32'h14, 32'hAABBCCDD, 1'b0, r, e, lat, bc);
    checks++; if (r !== 32'h11BBCC44) begin failures++; $display("FAIL lane_mid_data: got %h expected 11BBCC44", r); end
  endtask

  task automatic test_addr();
    logic [31:0] r; logic e; int lat, bc;
    sel = 1'b0;
    do_access(4'b0000, 32'h13, 32'h0, 1'b0, r, e, lat, bc);
    checks++; if (r !== 32'hDEABBEEF) begin failures++; $display("FAIL addr_lowbits: got %h expected DEABBEEF", r); end
    do_access(4'b1111, 32'h0, 32'h55667788, 1'b0, r, e, lat, bc);
    do_access(4'b1111, 32'h1000, 32'hFFFFFFFF, 1'b0, r, e, lat, bc);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_wr_err: got %b expected 1", e); end
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL oor_wr_data: got %h expected 00000000", r); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL oor_wr_latency: got %0d expected 2", lat); end
    do_access(4'b0000, 32'h1000, 32'h0, 1'b0, r, e, lat, bc);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_rd_err: got %b expected 1", e); end
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL oor_rd_data: got %h expected 00000000", r); end
    checks++; if (err_s !== 1'b0) begin failures++; $display("FAIL oor_err_pulse: got %b expected 0", err_s); end
    do_access(4'b0000, 32'h0, 32'h0, 1'b0, r, e, lat, bc);
    checks++; if (r !== 32'h55667788) begin failures++; $display("FAIL oor_word0: got %h expected 55667788", r); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL inrange_err: got %b expected 0", e); end
  endtask

  task automatic test_latency4();
    logic [31:0] r; logic e; int lat, bc;
    sel = 1'b1;
    do_access(4'b1111, 32'h20, 32'hA5A5A5A5, 1'b1, r, e, lat, bc);
    checks++; if (lat !== 5) begin failures++; $display("FAIL l4_wr_latency: got %0d expected 5", lat); end
    checks++; if (bc !== 5) begin failures++; $display("FAIL l4_wr_busy: got %0d expected 5", bc); end
    checks++; if (r !== 32'hA5A5A5A5) begin failures++; $display("FAIL l4_wr_captured: got %h expected A5A5A5A5", r); end
    do_access(4'b0000, 32'h20, 32'h0, 1'b0, r, e, lat, bc);
    checks++; if (lat !== 5) begin failures++; $display("FAIL l4_b2b_latency: got %0d expected 5", lat); end
    checks++; if (r !== 32'hA5A5A5A5) begin failures++; $display("FAIL l4_rd_data: got %h expected A5A5A5A5", r); end
  endtask

  task automatic test_reset_mid(input logic s, input logic [31:0] a, input logic [31:0] old_val);
    logic [31:0] r; logic e; int lat, bc;
    sel = s;
    we = 4'b1111; addr = a; wdata = 32'h12345678; en = 1'b1;
    @(negedge clk);
    checks++; if (busy_s !== 1'b1) begin failures++; $display("FAIL rstmid_busy_%0d: got %b expected 1", s, busy_s); end
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    checks++; if ({rd_s, ready_s, busy_s, err_s} !== 35'h0) begin failures++; $display("FAIL rstmid_outputs_%0d: got %h expected 0", s, {rd_s, ready_s, busy_s, err_s}); end
    rst = 1'b0;
    @(negedge clk);
    do_access(4'b0000, a, 32'h0, 1'b0, r, e, lat, bc);
    checks++; if (r !== old_val) begin failures++; $display("FAIL rstmid_old_%0d: got %h expected %h", s, r, old_val); end
  endtask

  task automatic test_idle();
    logic [31:0] r; logic e; int lat, bc;
    sel = 1'b0;
    do_access(4'b0000, 32'h10, 32'h0, 1'b0, r, e, lat, bc);
    for (int i = 0; i < 10; i++) begin
      checks++; if (rd_s !== 32'hDEABBEEF) begin failures++; $display("FAIL idle_rd[%0d]: got %h expected DEABBEEF", i, rd_s); end
      checks++; if ({ready_s, busy_s, err_s} !== 3'b000) begin failures++; $display("FAIL idle_flags[%0d]: got %b expected 000", i, {ready_s, busy_s, err_s}); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sel = 1'b0; we = 4'b0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_byte_lanes();
    test_addr();
    test_latency4();
    test_reset_mid(1'b0, 32'h10, 32'hDEABBEEF);
    test_reset_mid(1'b1, 32'h20, 32'hA5A5A5A5);
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
